// File: rtl/reg_file_pkg.sv
// reg_file_pkg: register-file sizing constants shared with the decode stage.
// The `define forms serve files that consume the constants without importing the package.
`ifndef REG_FILE_DEFS_SVH
`define REG_FILE_DEFS_SVH
`define REG_WIDTH  32
`define REG_DEPTH  32
`define REG_ADDR_W 5
`define REG_ZERO   0
`endif

package reg_file_pkg;

    localparam int REG_WIDTH  = `REG_WIDTH;
    localparam int REG_DEPTH  = `REG_DEPTH;
    localparam int REG_ADDR_W = `REG_ADDR_W;
    localparam int ZERO_REG   = `REG_ZERO;

endpackage

// File: rtl/reg_file_cell.sv
// reg_cell: one enabled D-register with synchronous active-high reset.
// Reset wins over the enable.
module reg_cell
    import reg_file_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg_file.sv
// reg_file: 32x32 register file, r0 hardwired to zero, two combinational
// read ports and one synchronous write port with a gate-level write decoder.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int DEPTH  = REG_DEPTH,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] rw,
    input  logic [WIDTH-1:0]  bus_w,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [WIDTH-1:0]  bus_a,
    output logic [WIDTH-1:0]  bus_b
);

    logic [ADDR_W-1:0] rw_n;
    logic [DEPTH-1:0]  wr_en;
    logic [WIDTH-1:0]  regs_q [DEPTH];

    for (genvar b = 0; b < ADDR_W; b++) begin : g_inv
        not u_inv (rw_n[b], rw[b]);
    end

    assign wr_en[ZERO_REG]  = 1'b0;
    assign regs_q[ZERO_REG] = '0;

    // Each line is an AND chain seeded with we, so an unknown rw cannot
    // raise any enable while we is low.
    for (genvar i = 1; i < DEPTH; i++) begin : g_line
        logic [ADDR_W:0] term;

        assign term[0] = we;

        for (genvar b = 0; b < ADDR_W; b++) begin : g_bit
            if (((i >> b) & 1) == 1) begin : g_hi
                and u_and (term[b+1], term[b], rw[b]);
            end else begin : g_lo
                and u_and (term[b+1], term[b], rw_n[b]);
            end
        end

        assign wr_en[i] = term[ADDR_W];

        reg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk_i (clk),
            .rst_i (rst),
            .en_i  (wr_en[i]),
            .d_i   (bus_w),
            .q_o   (regs_q[i])
        );
    end

    assign bus_a = regs_q[ra];
    assign bus_b = regs_q[rb];

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file against an array model.
// Inputs change away from the rising edge; outputs are sampled 1ns later.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  rw;
    logic [31:0] bus_w;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] bus_a;
    logic [31:0] bus_b;

    logic [31:0] model [32];
    int n_checks = 0;
    int n_fail   = 0;

    reg_file dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .rw    (rw),
        .bus_w (bus_w),
        .ra    (ra),
        .rb    (rb),
        .bus_a (bus_a),
        .bus_b (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Clocks one edge with the given controls and applies the same
    // effect to the model: reset clears all, else a write to non-zero.
    task automatic step(input logic r, input logic w, input logic [4:0] a,
                        input logic [31:0] d);
        @(negedge clk);
        rst = r; we = w; rw = a; bus_w = d;
        @(posedge clk);
        #1;
        if (r) begin
            for (int k = 0; k < 32; k++) model[k] = 32'h0;
        end else if (w && a != 5'd0) begin
            model[a] = d;
        end
        rst = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 5'd5, 32'hFFFF_FFFF);
        ra = 5'd5; rb = 5'd5; #1;
        n_checks++;
        if (bus_a !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_r5: got %h expected %h", bus_a, 32'h0);
        end
        for (int k = 0; k < 32; k++) begin
            ra = k[4:0]; rb = 5'(31 - k); #1;
            n_checks++;
            if (bus_a !== 32'h0 || bus_b !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_sweep r%0d: got %h/%h expected 0",
                         k, bus_a, bus_b);
            end
        end
    endtask

    task automatic test_write_read();
        step(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 5'd31, 32'h1234_5678);
        ra = 5'd7; rb = 5'd31; #1;
        n_checks++;
        if (bus_a !== 32'hDEAD_BEEF || bus_b !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL write_read: got %h/%h expected deadbeef/12345678",
                     bus_a, bus_b);
        end
        ra = 5'd6; rb = 5'd8; #1;
        n_checks++;
        if (bus_a !== 32'h0 || bus_b !== 32'h0) begin
            n_fail++;
            $display("FAIL neighbours: got %h/%h expected 0/0", bus_a, bus_b);
        end
    endtask

    task automatic test_zero_reg();
        step(1'b0, 1'b1, 5'd0, 32'hAAAA_5555);
        ra = 5'd0; rb = 5'd0; #1;
        n_checks++;
        if (bus_a !== 32'h0 || bus_b !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_reg: got %h/%h expected 0/0", bus_a, bus_b);
        end
    endtask

    task automatic test_same_cycle();
        step(1'b0, 1'b1, 5'd3, 32'h1);
        @(negedge clk);
        ra = 5'd3; we = 1'b1; rw = 5'd3; bus_w = 32'h2;
        #1;
        n_checks++;
        if (bus_a !== 32'h1) begin
            n_fail++;
            $display("FAIL same_cycle_before: got %h expected %h", bus_a, 32'h1);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        model[3] = 32'h2;
        n_checks++;
        if (bus_a !== 32'h2) begin
            n_fail++;
            $display("FAIL same_cycle_after: got %h expected %h", bus_a, 32'h2);
        end
    endtask

    task automatic test_we_gating();
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, 5'd9, 32'h5A5A_5A5A);
        ra = 5'd9; rb = 5'd9; #1;
        n_checks++;
        if (bus_a !== 32'h0 || bus_b !== 32'h0) begin
            n_fail++;
            $display("FAIL we_gating: got %h/%h expected 0/0", bus_a, bus_b);
        end
    endtask

    task automatic test_reset_midstream();
        for (int k = 1; k < 32; k++) step(1'b0, 1'b1, k[4:0], 32'(k));
        for (int k = 0; k < 32; k++) begin
            ra = k[4:0]; #1;
            n_checks++;
            if (bus_a !== 32'(k)) begin
                n_fail++;
                $display("FAIL fill r%0d: got %h expected %h", k, bus_a, 32'(k));
            end
        end
        step(1'b1, 1'b1, 5'd4, 32'h77);
        for (int k = 0; k < 32; k++) begin
            ra = k[4:0]; rb = k[4:0]; #1;
            n_checks++;
            if (bus_a !== 32'h0 || bus_b !== 32'h0) begin
                n_fail++;
                $display("FAIL midreset r%0d: got %h/%h expected 0",
                         k, bus_a, bus_b);
            end
        end
    endtask

    task automatic test_random();
        logic        r;
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 40) == 0);
            w = ($urandom_range(0, 3) != 0);
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            step(r, w, a, d);
            ra = 5'($urandom_range(0, 31));
            rb = (n % 5 == 0) ? ra : 5'($urandom_range(0, 31));
            #1;
            n_checks++;
            if (bus_a !== model[ra] || bus_b !== model[rb]) begin
                n_fail++;
                $display("FAIL random ra=%0d rb=%0d: got %h/%h expected %h/%h",
                         ra, rb, bus_a, bus_b, model[ra], model[rb]);
            end
        end
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; rw = '0; bus_w = '0; ra = '0; rb = '0;
        for (int k = 0; k < 32; k++) model[k] = 32'h0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_same_cycle();
        test_we_gating();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
